tmds_dc_balance: RTL and testbench



---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_ones_count.sv | 14 +
 rtl/tmds_dc_balance.sv | 86 ++++++++
 tb/tb_tmds_dc_balance.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS types and control tokens used by the channel encoder stages.
package tmds_pkg;

  typedef logic [9:0] tmds_sym_t;
  typedef logic [8:0] q_m_t;

  localparam tmds_sym_t CTRL_TOKEN_00 = 10'h354;
  localparam tmds_sym_t CTRL_TOKEN_01 = 10'h0AB;
  localparam tmds_sym_t CTRL_TOKEN_10 = 10'h154;
  localparam tmds_sym_t CTRL_TOKEN_11 = 10'h2AB;

  // Map the blanking-period control bits {c1,c0} to their 10-bit token.
  function automatic tmds_sym_t ctrl_token(input logic [1:0] ctrl);
    tmds_sym_t tok;
    unique case (ctrl)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_ones_count.sv
// Combinational population count of an 8-bit word (0..8).
module tmds_ones_count (
  input  logic [7:0] data_i,
  output logic [3:0] count_c_o
);

  always_comb begin
    count_c_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_c_o = count_c_o + 4'(data_i[i]);
    end
  end

endmodule

// File: rtl/tmds_dc_balance.sv
// TMDS DC-balance stage: conditional inversion driven by a running disparity
// counter, control tokens during blanking, one registered symbol per clock.
module tmds_dc_balance
  import tmds_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [8:0]       q_m_in,
  input  logic             ve_in,
  input  logic [1:0]       ctrl_in,
  output logic [9:0]       tmds_out,
  output logic [CNT_W-1:0] disparity_out
);

  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

  logic [3:0]              n1;
  logic signed [CNT_W-1:0] n1_s;
  logic signed [CNT_W-1:0] n0_s;
  logic signed [CNT_W-1:0] cnt_q;
  logic signed [CNT_W-1:0] cnt_d;
  tmds_sym_t               tmds_q;
  tmds_sym_t               tmds_d;
  logic                    q8;
  logic [7:0]              data;
  logic                    cnt_zero;
  logic                    cnt_neg;
  logic                    cnt_pos;
  logic                    ones_more;
  logic                    zeros_more;
  logic                    even;

  tmds_ones_count u_ones (
    .data_i    (q_m_in[7:0]),
    .count_c_o (n1)
  );

  // Operand decode: signed ones/zeros counts and the counter's sign.
  always_comb begin
    q8         = q_m_in[8];
    data       = q_m_in[7:0];
    n1_s       = $signed(CNT_W'(n1));
    n0_s       = $signed(CNT_W'(4'd8 - n1));
    cnt_zero   = (cnt_q == '0);
    cnt_neg    = cnt_q[CNT_W-1];
    cnt_pos    = !cnt_neg && !cnt_zero;
    ones_more  = (n1 > 4'd4);
    zeros_more = (n1 < 4'd4);
    even       = (n1 == 4'd4);
  end

  // Branch priority: control, balanced, invert, pass-through.
  always_comb begin
    tmds_d = tmds_q;
    cnt_d  = cnt_q;
    if (!ve_in) begin
      tmds_d = ctrl_token(ctrl_in);
      cnt_d  = '0;
    end else if (cnt_zero || even) begin
      tmds_d = {~q8, q8, (q8 ? data : ~data)};
      cnt_d  = q8 ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
    end else if ((cnt_pos && ones_more) || (cnt_neg && zeros_more)) begin
      tmds_d = {1'b1, q8, ~data};
      cnt_d  = cnt_q + (q8 ? TWO : '0) + n0_s - n1_s;
    end else begin
      tmds_d = {1'b0, q8, data};
      cnt_d  = cnt_q - (q8 ? '0 : TWO) + n1_s - n0_s;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmds_q <= '0;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_out      = tmds_q;
  assign disparity_out = $unsigned(cnt_q);

endmodule

// File: tb/tb_tmds_dc_balance.sv
// Scoreboard bench for tmds_dc_balance: directed hand-computed vectors,
// asynchronous reset, and a randomised run against a behavioural model.
module tb_tmds_dc_balance;

  localparam int unsigned CNT_W = 5;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [8:0]       q_m_in;
  logic             ve_in;
  logic [1:0]       ctrl_in;
  logic [9:0]       tmds_out;
  logic [CNT_W-1:0] disparity_out;

  tmds_dc_balance #(.CNT_W(CNT_W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .q_m_in        (q_m_in),
    .ve_in         (ve_in),
    .ctrl_in       (ctrl_in),
    .tmds_out      (tmds_out),
    .disparity_out (disparity_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [9:0] tmds;
    int         cnt;
    logic       video;
    logic [8:0] qm;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  bit         no_wait  = 1'b0;
  int         mcnt     = 0;
  logic [9:0] tok [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int disp_now();
    return int'($signed(disparity_out));
  endfunction

  // Monitor: one symbol per clock, compared just after the edge that produced it.
  always @(posedge clk_in) begin
    exp_t       e;
    logic [7:0] dec;
    int         d;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, " tmds"}, int'(tmds_out), int'(e.tmds));
      chk({e.tag, " cnt"}, disp_now(), e.cnt);
      d = disp_now();
      chk({e.tag, " cnt_bound"}, int'(d <= 10 && d >= -10), 1);
      if (e.video) begin
        dec = tmds_out[9] ? ~tmds_out[7:0] : tmds_out[7:0];
        chk({e.tag, " decode"}, int'({tmds_out[8], dec}), int'(e.qm));
      end
    end
  end

  task automatic drive(input logic ve, input logic [1:0] c, input logic [8:0] qm,
                       input logic [9:0] et, input int ec, input string tag);
    exp_t e;
    if (!no_wait) @(negedge clk_in);
    no_wait = 1'b0;
    ve_in   = ve;
    ctrl_in = c;
    q_m_in  = qm;
    e.tmds  = et;
    e.cnt   = ec;
    e.video = ve;
    e.qm    = qm;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    no_wait  = 1'b1;
    mcnt     = 0;
  endtask

  function automatic int popc8(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Behavioural model of one symbol, straight from the branch definitions.
  task automatic rnd_step(input int idx);
    logic       ve;
    logic [1:0] c;
    logic [8:0] qm;
    logic [9:0] sym;
    logic       q8;
    logic [7:0] d;
    int         n1, n0;
    ve = ($urandom_range(0, 7) != 0);
    c  = 2'($urandom_range(0, 3));
    qm = 9'($urandom_range(0, 511));
    q8 = qm[8];
    d  = qm[7:0];
    n1 = popc8(d);
    n0 = 8 - n1;
    if (!ve) begin
      sym  = tok[c];
      mcnt = 0;
    end else if (mcnt == 0 || n1 == n0) begin
      sym  = {~q8, q8, (q8 ? d : ~d)};
      mcnt = mcnt + (q8 ? (n1 - n0) : (n0 - n1));
    end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
      sym  = {1'b1, q8, ~d};
      mcnt = mcnt + (q8 ? 2 : 0) + n0 - n1;
    end else begin
      sym  = {1'b0, q8, d};
      mcnt = mcnt - (q8 ? 0 : 2) + n1 - n0;
    end
    drive(ve, c, qm, sym, mcnt, $sformatf("rnd%0d", idx));
  endtask

  initial begin
    rst_n_in = 1'b0;
    ve_in    = 1'b0;
    ctrl_in  = 2'b00;
    q_m_in   = '0;
    #12;
    chk("reset tmds", int'(tmds_out), 0);
    chk("reset cnt", disp_now(), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    no_wait  = 1'b1;

    // Control tokens
    drive(1'b0, 2'b00, 9'h000, 10'h354, 0, "ctrl00");
    drive(1'b0, 2'b01, 9'h000, 10'h0AB, 0, "ctrl01");
    drive(1'b0, 2'b10, 9'h000, 10'h154, 0, "ctrl10");
    drive(1'b0, 2'b11, 9'h000, 10'h2AB, 0, "ctrl11");

    do_reset();
    drive(1'b1, 2'b00, 9'h100, 10'h100, -8, "xor0_first");
    drive(1'b1, 2'b00, 9'h100, 10'h3FF,  2, "xor0_invert");

    do_reset();
    drive(1'b1, 2'b00, 9'h0F0, 10'h20F,  0, "xnor_even");
    drive(1'b1, 2'b00, 9'h100, 10'h100, -8, "to_m8");
    drive(1'b0, 2'b00, 9'h100, 10'h354,  0, "ctrl_clears");
    drive(1'b1, 2'b00, 9'h100, 10'h100, -8, "after_ctrl");
    drive(1'b1, 2'b00, 9'h0FF, 10'h0FF, -2, "neg_pass");
    drive(1'b1, 2'b00, 9'h1F0, 10'h1F0, -2, "even_xor");
    drive(1'b1, 2'b00, 9'h101, 10'h3FE,  6, "neg_invert");
    drive(1'b1, 2'b00, 9'h0FE, 10'h201,  0, "pos_invert");
    drive(1'b1, 2'b00, 9'h003, 10'h2FC,  4, "zero_xnor");
    drive(1'b1, 2'b00, 9'h1FF, 10'h300, -2, "pos_invert_xor");

    // Asynchronous reset between edges with cnt = +2
    do_reset();
    drive(1'b1, 2'b00, 9'h100, 10'h100, -8, "pre_ar1");
    drive(1'b1, 2'b00, 9'h100, 10'h3FF,  2, "pre_ar2");
    @(posedge clk_in);
    #3;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst tmds", int'(tmds_out), 0);
    chk("async_rst cnt", disp_now(), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    no_wait  = 1'b1;
    mcnt     = 0;
    drive(1'b1, 2'b00, 9'h100, 10'h100, -8, "post_ar");

    do_reset();
    for (int i = 0; i < 4000; i++) rnd_step(i);

    @(negedge clk_in);
    ve_in = 1'b0;
    @(posedge clk_in);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
